// File: rtl/pattern_timing_gen.sv
// Frame/line timing generator for the pattern generator.
// Shadows the generator configuration so it only changes at frame start.
module pattern_timing_gen #(
    parameter int LINE_LEN = 4096,
    parameter int H_BLANK  = 16,
    parameter int LINES    = 32,
    parameter int V_BLANK  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        cfg_wr,
    input  logic [11:0] cfg_const,
    input  logic [1:0]  cfg_x,
    input  logic [1:0]  cfg_y,
    input  logic [2:0]  cfg_mode,
    output logic        f_sync,
    output logic        sync,
    output logic        active,
    output logic [11:0] const_val,
    output logic [1:0]  x,
    output logic [1:0]  y,
    output logic [2:0]  mode,
    output logic        cfg_pend,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam int P  = 1 + LINE_LEN + H_BLANK;
    localparam int NL = LINES + V_BLANK;
    localparam int PW = (P > 1) ? $clog2(P) : 1;
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [PW-1:0] PIX_ACT_END = PW'(LINE_LEN);
    localparam logic [PW-1:0] PIX_END     = PW'(P - 1);
    localparam logic [LW-1:0] LAST_ACT    = LW'(LINES - 1);
    localparam logic [LW-1:0] LAST_LINE   = LW'(NL - 1);

    typedef enum logic [2:0] {
        IDLE, FSYNC, SYNC, ACTIVE, HBLANK, VBLANK
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [LW-1:0] line_q, line_d;
    logic          line_end, frame_end;

    logic          f_sync_q, f_sync_d;
    logic          sync_q, sync_d;
    logic          active_q, active_d;
    logic          busy_q, busy_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [11:0]   const_val_q, const_val_d;
    logic [1:0]    x_q, x_d, y_q, y_d;
    logic [2:0]    mode_q, mode_d;
    logic          cfg_pend_q, cfg_pend_d;
    logic [11:0]   p_const_q, p_const_d;
    logic [1:0]    p_x_q, p_x_d, p_y_q, p_y_d;
    logic [2:0]    p_mode_q, p_mode_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            line_q      <= '0;
            f_sync_q    <= 1'b0;
            sync_q      <= 1'b0;
            active_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            const_val_q <= '0;
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= '0;
            cfg_pend_q  <= 1'b0;
            p_const_q   <= '0;
            p_x_q       <= '0;
            p_y_q       <= '0;
            p_mode_q    <= '0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            line_q      <= line_d;
            f_sync_q    <= f_sync_d;
            sync_q      <= sync_d;
            active_q    <= active_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            const_val_q <= const_val_d;
            x_q         <= x_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            cfg_pend_q  <= cfg_pend_d;
            p_const_q   <= p_const_d;
            p_x_q       <= p_x_d;
            p_y_q       <= p_y_d;
            p_mode_q    <= p_mode_d;
        end
    end

    // pix counts 0..P-1 within a line period; line runs over active and blank lines
    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        line_d    = line_q;
        line_end  = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = FSYNC;
            end
            FSYNC: begin
                state_d = SYNC;
                pix_d   = '0;
                line_d  = '0;
            end
            SYNC: begin
                state_d = ACTIVE;
                pix_d   = pix_q + 1'b1;
            end
            ACTIVE: begin
                pix_d = pix_q + 1'b1;
                if (pix_q == PIX_ACT_END) begin
                    if (H_BLANK > 0) state_d = HBLANK;
                    else line_end = 1'b1;
                end
            end
            HBLANK: begin
                pix_d = pix_q + 1'b1;
                if (pix_q == PIX_END) line_end = 1'b1;
            end
            VBLANK: begin
                pix_d = pix_q + 1'b1;
                if (pix_q == PIX_END) begin
                    pix_d  = '0;
                    line_d = line_q + 1'b1;
                    if (line_q == LAST_LINE) frame_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (line_end) begin
            pix_d  = '0;
            line_d = line_q + 1'b1;
            if (line_q != LAST_ACT) state_d = SYNC;
            else if (V_BLANK > 0) state_d = VBLANK;
            else frame_end = 1'b1;
        end
        if (frame_end) state_d = enable ? FSYNC : IDLE;
    end

    always_comb begin
        f_sync_d    = (state_d == FSYNC);
        sync_d      = (state_d == SYNC);
        active_d    = (state_d == ACTIVE);
        busy_d      = (state_d != IDLE);
        frame_cnt_d = frame_cnt_q;
        const_val_d = const_val_q;
        x_d         = x_q;
        y_d         = y_q;
        mode_d      = mode_q;
        cfg_pend_d  = cfg_pend_q;
        p_const_d   = p_const_q;
        p_x_d       = p_x_q;
        p_y_d       = p_y_q;
        p_mode_d    = p_mode_q;
        // FSYNC is one cycle long, so state_d==FSYNC is always an entry edge
        if (f_sync_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (cfg_pend_q) begin
                const_val_d = p_const_q;
                x_d         = p_x_q;
                y_d         = p_y_q;
                mode_d      = p_mode_q;
                cfg_pend_d  = 1'b0;
            end
        end
        if (cfg_wr) begin
            p_const_d  = cfg_const;
            p_x_d      = cfg_x;
            p_y_d      = cfg_y;
            p_mode_d   = cfg_mode;
            cfg_pend_d = 1'b1;
        end
    end

    assign f_sync    = f_sync_q;
    assign sync      = sync_q;
    assign active    = active_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign const_val = const_val_q;
    assign x         = x_q;
    assign y         = y_q;
    assign mode      = mode_q;
    assign cfg_pend  = cfg_pend_q;

endmodule

// File: tb/tb_pattern_timing_gen.sv
// Self-checking bench for pattern_timing_gen: vector table, corner
// sequences and random stimulus against a frame-position model.
`timescale 1ns/1ps
module tb_pattern_timing_gen;
  localparam int LL = 8;
  localparam int HB = 2;
  localparam int NLI = 3;
  localparam int VB = 1;
  localparam int P = 1 + LL + HB;
  localparam int FRAME = 1 + (NLI + VB) * P;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic en2 = 1'b0;
  logic cfg_wr = 1'b0;
  logic [11:0] cfg_const = '0;
  logic [1:0] cfg_x = '0;
  logic [1:0] cfg_y = '0;
  logic [2:0] cfg_mode = '0;

  logic f_sync, sync, active, busy, cfg_pend;
  logic [11:0] const_val;
  logic [1:0] x, y;
  logic [2:0] mode;
  logic [15:0] frame_cnt;

  logic f_sync2, sync2, active2, busy2, cfg_pend2;
  logic [11:0] const_val2;
  logic [1:0] x2, y2;
  logic [2:0] mode2;
  logic [15:0] frame_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_timing_gen #(
    .LINE_LEN(LL), .H_BLANK(HB),
    .LINES(NLI), .V_BLANK(VB)
  ) dut (
    .clk(clk), .rst(rst),
    .enable(enable), .cfg_wr(cfg_wr),
    .cfg_const(cfg_const), .cfg_x(cfg_x),
    .cfg_y(cfg_y), .cfg_mode(cfg_mode),
    .f_sync(f_sync), .sync(sync),
    .active(active), .const_val(const_val),
    .x(x), .y(y), .mode(mode),
    .cfg_pend(cfg_pend), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  pattern_timing_gen #(
    .LINE_LEN(1), .H_BLANK(0),
    .LINES(1), .V_BLANK(0)
  ) dut2 (
    .clk(clk), .rst(rst),
    .enable(en2), .cfg_wr(cfg_wr),
    .cfg_const(cfg_const), .cfg_x(cfg_x),
    .cfg_y(cfg_y), .cfg_mode(cfg_mode),
    .f_sync(f_sync2), .sync(sync2),
    .active(active2), .const_val(const_val2),
    .x(x2), .y(y2), .mode(mode2),
    .cfg_pend(cfg_pend2), .busy(busy2),
    .frame_cnt(frame_cnt2)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Reference: a frame is FRAME cycles; position within it decides pulses
  logic m_run = 1'b0;
  int m_pos = 0;
  logic [15:0] m_cnt = '0;
  logic m_pend = 1'b0;
  logic [11:0] m_pc = '0, m_cv = '0;
  logic [1:0] m_px = '0, m_py = '0, m_x = '0, m_y = '0;
  logic [2:0] m_pm = '0, m_m = '0;
  wire m_start = enable && (!m_run || m_pos == FRAME - 1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_pos <= 0; m_cnt <= '0;
      m_pend <= 1'b0; m_pc <= '0; m_cv <= '0;
      m_px <= '0; m_py <= '0; m_x <= '0;
      m_y <= '0; m_pm <= '0; m_m <= '0;
    end else begin
      if (m_start) begin
        m_run <= 1'b1;
        m_pos <= 0;
        m_cnt <= m_cnt + 16'd1;
        if (m_pend) begin
          m_cv <= m_pc; m_x <= m_px;
          m_y <= m_py; m_m <= m_pm;
        end
      end else if (m_run && m_pos == FRAME - 1)
        m_run <= 1'b0;
      else if (m_run)
        m_pos <= m_pos + 1;
      if (cfg_wr) begin
        m_pend <= 1'b1; m_pc <= cfg_const;
        m_px <= cfg_x; m_py <= cfg_y;
        m_pm <= cfg_mode;
      end else if (m_start)
        m_pend <= 1'b0;
    end
  end

  function automatic logic [39:0] model_exp();
    logic fs, sy, ac, bz;
    int r, ln;
    fs = 0; sy = 0; ac = 0; bz = 0;
    if (m_run) begin
      bz = 1;
      if (m_pos == 0) fs = 1;
      else begin
        r = (m_pos - 1) % P;
        ln = (m_pos - 1) / P;
        sy = (ln < NLI) && (r == 0);
        ac = (ln < NLI) && (r >= 1) && (r <= LL);
      end
    end
    return {fs, sy, ac, bz, m_pend, m_cnt,
            m_cv, m_x, m_y, m_m};
  endfunction

  always @(negedge clk)
    chk("model",
        64'({f_sync, sync, active, busy, cfg_pend,
             frame_cnt, const_val, x, y, mode}),
        64'(model_exp()));

  task automatic wait_fs(output int n);
    n = 0;
    @(negedge clk);
    while (!f_sync && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("fs_seen", 64'(f_sync), 64'(1));
  endtask

  typedef struct {
    int off;
    logic [3:0] sig;
    logic [15:0] fc;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tab[13];
    logic [3:0] pat[3];
    int n, cur, nfs;
    tab[0]  = '{0,  4'b1001, 16'd1};
    tab[1]  = '{1,  4'b0101, 16'd1};
    tab[2]  = '{2,  4'b0011, 16'd1};
    tab[3]  = '{9,  4'b0011, 16'd1};
    tab[4]  = '{10, 4'b0001, 16'd1};
    tab[5]  = '{11, 4'b0001, 16'd1};
    tab[6]  = '{12, 4'b0101, 16'd1};
    tab[7]  = '{23, 4'b0101, 16'd1};
    tab[8]  = '{31, 4'b0011, 16'd1};
    tab[9]  = '{33, 4'b0001, 16'd1};
    tab[10] = '{34, 4'b0001, 16'd1};
    tab[11] = '{44, 4'b0001, 16'd1};
    tab[12] = '{45, 4'b1001, 16'd2};
    pat[0] = 4'b1001;
    pat[1] = 4'b0101;
    pat[2] = 4'b0011;

    #12;
    chk("reset_outs",
        64'({f_sync, sync, active, busy, cfg_pend,
             frame_cnt, const_val, x, y, mode}),
        64'(0));
    @(negedge clk); rst = 1'b0;
    @(negedge clk); enable = 1'b1;
    wait_fs(n);
    chk("fs_latency", 64'(n), 64'(0));

    cur = 0;
    for (int i = 0; i < 13; i++) begin
      repeat (tab[i].off - cur) @(negedge clk);
      cur = tab[i].off;
      chk($sformatf("vec%0d", i),
          64'({f_sync, sync, active, busy, frame_cnt}),
          64'({tab[i].sig, tab[i].fc}));
    end

    repeat (3) @(negedge clk);
    cfg_wr = 1'b1; cfg_const = 12'hABC;
    cfg_mode = 3'd2; cfg_x = 2'd1; cfg_y = 2'd3;
    @(negedge clk); cfg_wr = 1'b0;
    chk("pend_set", 64'({cfg_pend, const_val, mode}),
        64'({1'b1, 12'h000, 3'd0}));
    wait_fs(n);
    chk("cfg_apply",
        64'({cfg_pend, const_val, x, y, mode}),
        64'({1'b0, 12'hABC, 2'd1, 2'd3, 3'd2}));

    repeat (10) @(negedge clk);
    cfg_wr = 1'b1; cfg_const = 12'h456;
    cfg_mode = 3'd5; cfg_x = 2'd2; cfg_y = 2'd0;
    @(negedge clk); cfg_wr = 1'b0;
    repeat (33) @(negedge clk);
    chk("last_cycle", 64'({f_sync, busy}), 64'(2'b01));
    cfg_wr = 1'b1; cfg_const = 12'h123;
    cfg_mode = 3'd1; cfg_x = 2'd3; cfg_y = 2'd1;
    @(negedge clk); cfg_wr = 1'b0;
    chk("same_edge",
        64'({f_sync, cfg_pend, const_val, mode}),
        64'({1'b1, 1'b1, 12'h456, 3'd5}));
    wait_fs(n);
    chk("late_apply",
        64'({cfg_pend, const_val, x, y, mode}),
        64'({1'b0, 12'h123, 2'd3, 2'd1, 3'd1}));

    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (39) @(negedge clk);
    chk("busy_hold", 64'(busy), 64'(1));
    @(negedge clk);
    chk("busy_fall", 64'({busy, f_sync}), 64'(0));
    nfs = 0;
    repeat (50) begin
      @(negedge clk);
      if (f_sync) nfs++;
    end
    chk("no_fs", 64'(nfs), 64'(0));
    chk("idle", 64'({busy, active, sync}), 64'(0));

    enable = 1'b1;
    wait_fs(n);
    repeat (2) @(negedge clk);
    cfg_wr = 1'b1; cfg_const = 12'h321;
    @(negedge clk); cfg_wr = 1'b0;
    chk("pre_rst", 64'({active, cfg_pend}), 64'(2'b11));
    #2 rst = 1'b1;
    #1;
    chk("async_rst",
        64'({f_sync, sync, active, busy, cfg_pend,
             frame_cnt, const_val, mode}),
        64'(0));
    @(negedge clk); rst = 1'b0;
    wait_fs(n);
    chk("post_rst_lat", 64'(n), 64'(0));
    chk("post_rst",
        64'({frame_cnt, const_val, cfg_pend}),
        64'({16'd1, 12'd0, 1'b0}));

    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 19) != 0);
      cfg_wr = ($urandom_range(0, 7) == 0);
      cfg_const = 12'($urandom);
      cfg_x = 2'($urandom);
      cfg_y = 2'($urandom);
      cfg_mode = 3'($urandom);
    end
    @(negedge clk);
    cfg_wr = 1'b0;
    enable = 1'b0;

    en2 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!f_sync2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("p3_start", 64'(f_sync2), 64'(1));
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("p3_%0d", k),
          64'({f_sync2, sync2, active2, busy2}),
          64'(pat[k % 3]));
      @(negedge clk);
    end
    force dut2.frame_cnt_q = 16'hFFFF;
    #1 release dut2.frame_cnt_q;
    @(negedge clk);
    chk("fc_ffff", 64'(frame_cnt2), 64'(16'hFFFF));
    repeat (2) @(negedge clk);
    chk("fc_wrap", 64'({f_sync2, frame_cnt2}),
        64'({1'b1, 16'h0000}));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/pattern_timing_gen.md
Name: pattern_timing_gen

Overview:
- Upstream neighbour of the pattern generator top level. It produces the frame-start pulse (f_sync) and the line-start pulses (sync) that drive the generator.
- It also holds the generator's configuration (constVal, X, Y, Mode) in shadow registers. A new configuration takes effect only at a frame boundary, so the generator never sees a change mid-frame.
- The frame is a raster of active lines followed by vertical blanking lines. Each line is one sync cycle, then active pixel cycles, then horizontal blanking cycles.

Parameters:
- LINE_LEN, 4096: active pixel cycles per line (>=1).
- H_BLANK, 16: blank cycles after the active pixels of each line (>=0).
- LINES, 32: active lines per frame (>=1).
- V_BLANK, 2: blank line periods after the active lines (>=0).

Ports:
- clk  in  1  master clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  level; 1 = run frames continuously, 0 = stop after the current frame.
- cfg_wr  in  1  one-cycle strobe; latches the cfg_* inputs into the pending registers.
- cfg_const  in  12  pending constant value.
- cfg_x  in  2  pending deltaX.
- cfg_y  in  2  pending deltaY.
- cfg_mode  in  3  pending work mode.
- f_sync  out  1  one-cycle frame-start pulse.
- sync  out  1  one-cycle line-start pulse (active lines only).
- active  out  1  high during active pixel cycles.
- const_val  out  12  applied constant value.
- x  out  2  applied deltaX.
- y  out  2  applied deltaY.
- mode  out  3  applied work mode.
- cfg_pend  out  1  a written configuration is waiting to be applied.
- busy  out  1  high from the f_sync cycle through the last cycle of the frame.
- frame_cnt  out  16  number of frames started.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - All outputs are 0.
  - Pending registers are 0.
  - The FSM goes to IDLE.
- All outputs are registered. Line period P = 1 + LINE_LEN + H_BLANK cycles.
- FSM states: IDLE, FSYNC, SYNC, ACTIVE, HBLANK, VBLANK.
  - IDLE: if enable=1, go to FSYNC on the next edge.
  - FSYNC: lasts 1 cycle. f_sync=1 and busy=1. Go to SYNC.
  - SYNC: lasts 1 cycle. sync=1. Go to ACTIVE.
  - ACTIVE: lasts LINE_LEN cycles. active=1. Go to HBLANK, or to the H_BLANK=0 path below.
  - HBLANK: lasts H_BLANK cycles. At the end:
    - if line < LINES-1, go to SYNC;
    - otherwise go to VBLANK, or to the V_BLANK=0 path below.
  - When H_BLANK=0, ACTIVE proceeds directly as if HBLANK had ended.
  - VBLANK: lasts V_BLANK*P cycles with all pulses low. At the end:
    - if enable=1, go to FSYNC (back-to-back frames, no gap);
    - otherwise go to IDLE.
  - When V_BLANK=0, the last HBLANK proceeds directly as if VBLANK had ended.
- Frame length = 1 + (LINES + V_BLANK)*P cycles. busy is high for that whole span.
- Internal counters: pixel counter of $clog2(P) bits, line counter of $clog2(LINES+V_BLANK) bits. Both clear at FSYNC.
- enable sampling:
  - Sampled only in IDLE and on the last cycle of a frame.
  - Deasserting enable mid-frame never truncates the frame.
- Configuration:
  - cfg_wr=1 loads the pending registers and sets cfg_pend=1. The last write before application wins.
  - On the edge that enters FSYNC, if cfg_pend=1, the pending values are copied to const_val/x/y/mode and cfg_pend clears. The applied outputs are therefore valid in the f_sync cycle and hold for the whole frame.
  - If cfg_wr and the FSYNC entry occur on the same edge: the old pending value is applied, the new write is stored in pending, and cfg_pend stays 1.
- frame_cnt increments on the edge entering FSYNC and wraps from 0xFFFF to 0.
- f_sync and sync are never high in the same cycle. sync is never asserted during VBLANK.

Test Plan:
- Params LINE_LEN=8, H_BLANK=2, LINES=3, V_BLANK=1; rst then enable=1 -> f_sync one cycle later; sync pulses at offsets 1, 12, 23 from f_sync; active for 8 cycles after each sync; next f_sync at offset 45; frame_cnt=1, then 2.
- cfg_wr with cfg_const=0xABC, mode=2 mid-frame -> cfg_pend=1; outputs unchanged until the next f_sync; in the f_sync cycle const_val=0xABC, mode=2, cfg_pend=0.
- cfg_wr with cfg_const=0x123 on the edge entering FSYNC -> old pending applied; const_val≠0x123 this frame; cfg_pend=1; 0x123 applied at the following f_sync.
- enable dropped at offset 5 of a frame -> frame completes all 45 cycles; busy falls at offset 45; no further f_sync; FSM in IDLE.
- rst asserted during ACTIVE -> f_sync/sync/active/busy/frame_cnt/cfg_pend go to 0 immediately (asynchronously); after release with enable=1 -> a fresh frame starting with f_sync, frame_cnt=1.
- H_BLANK=0, V_BLANK=0, LINE_LEN=1, LINES=1 -> period 3; output sequence f_sync, sync, active repeating with no gaps; frame_cnt forced to 0xFFFF wraps to 0.
